// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl
//  Description : Sequencing controller for a free-running up-counter.
//                Drives the counter enable/clear, watches q for a latched
//                terminal value and produces one-shot or periodic wrap/done
//                events, with an optional finite number of periodic passes.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [WIDTH-1:0]    term,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic [WIDTH-1:0]    q,
    output logic                cnt_en,
    output logic                cnt_clr,
    output logic                busy,
    output logic                wrap,
    output logic                done,
    output logic [REPEAT_W-1:0] pass_cnt
);

    // Controller states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_term;
    logic                r_mode;
    logic [REPEAT_W-1:0] r_repeat;
    logic [REPEAT_W-1:0] r_pass_cnt;

    logic [1:0]          w_state_nxt;
    logic                w_accept;
    logic                w_pass_inc;
    logic                w_hit;
    logic                w_last_pass;
    logic [REPEAT_W-1:0] w_pass_next;

    // Terminal compare is only meaningful while counting; full-width match.
    assign w_hit       = (r_state == c_st_run) && (q == r_term);
    assign w_pass_next = r_pass_cnt + 1'b1;
    // One-shot always finishes on its first hit; periodic finishes when the
    // pass about to complete is the last requested one (repeat 0 = forever).
    assign w_last_pass = !r_mode || ((r_repeat != '0) && (w_pass_next == r_repeat));
    assign pass_cnt    = r_pass_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run configuration is captured only when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_term   <= '0;
            r_mode   <= 1'b0;
            r_repeat <= '0;
        end else if (w_accept) begin
            r_term   <= term;
            r_mode   <= mode;
            r_repeat <= repeat_cnt;
        end
    end

    // Completed-pass counter: cleared on a new run, bumped on each hit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_cnt <= '0;
        end else if (w_accept) begin
            r_pass_cnt <= '0;
        end else if (w_pass_inc) begin
            r_pass_cnt <= w_pass_next;
        end
    end

    // Next-state and output decode; stop outranks a simultaneous hit in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pass_inc  = 1'b0;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b0;
        busy        = 1'b0;
        wrap        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start && !stop) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_clear;
                end
            end
            c_st_clear: begin
                // The clear is issued even when the run is being aborted.
                cnt_clr     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = stop ? c_st_idle : c_st_run;
            end
            c_st_run: begin
                busy = 1'b1;
                if (stop) begin
                    w_state_nxt = c_st_idle;
                end else if (!w_hit) begin
                    cnt_en = 1'b1;
                end else begin
                    wrap       = 1'b1;
                    w_pass_inc = 1'b1;
                    if (w_last_pass) begin
                        w_state_nxt = c_st_done;
                    end else begin
                        // Restart the next pass from zero.
                        cnt_clr = 1'b1;
                    end
                end
            end
            c_st_done: begin
                done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencing controller for the team's free-running up-counter datapath. The counter has a WIDTH-bit q output, a synchronous clear with priority, and an enable.
- The controller drives the counter's enable and clear, watches q for a programmed terminal value, and produces one-shot or periodic timing events.
- It sits between a software or FSM requester (start/stop handshake) and the counter instance.

Parameters:
WIDTH, 4, counter width; width of q and term
REPEAT_W, 4, width of repeat_cnt and pass_cnt

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a run; sampled only in IDLE
stop  input  1  abort the current run; sampled in CLEAR/RUN
mode  input  1  0 = one-shot, 1 = periodic; latched on accepted start
term  input  WIDTH  terminal count; latched on accepted start
repeat_cnt  input  REPEAT_W  periodic pass count, 0 = infinite; latched on accepted start
q  input  WIDTH  counter value from the counter datapath
cnt_en  output  1  counter increment enable
cnt_clr  output  1  counter synchronous clear
busy  output  1  high in CLEAR and RUN
wrap  output  1  1-cycle pulse when q reaches the terminal count in RUN
done  output  1  1-cycle pulse at normal completion
pass_cnt  output  REPEAT_W  completed passes in the current run

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state = IDLE; term_r, mode_r, repeat_r and pass_cnt = 0; cnt_en, cnt_clr, busy, wrap and done = 0. A reset mid-run returns the block to IDLE on the same edge, with no done.
- Counter contract: on a clk edge, cnt_clr sets q to 0 (priority); otherwise cnt_en increments q by 1 modulo 2^WIDTH.
- hit = RUN && (q == term_r). The compare is on the full WIDTH bits.
- Outputs are combinational decodes of the registered state, hit and stop.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - All control outputs 0.
  - start && !stop: latch term, mode and repeat_cnt; clear pass_cnt; go to CLEAR.
  - start && stop in the same cycle: stay in IDLE.
- CLEAR:
  - cnt_clr = 1, cnt_en = 0, busy = 1.
  - stop: go to IDLE (the clear still takes effect). Otherwise go to RUN.
- RUN:
  - busy = 1.
  - stop (priority over hit): cnt_en = 0, wrap = 0; go to IDLE. pass_cnt holds; no done.
  - !hit: cnt_en = 1.
  - hit: cnt_en = 0, wrap = 1, pass_cnt increments by 1 (wraps modulo 2^REPEAT_W).
    - Finish when mode_r == 0, or when repeat_r != 0 && pass_cnt + 1 == repeat_r: go to DONE.
    - Otherwise cnt_clr = 1 and stay in RUN. q restarts from 0 on the next cycle.
- DONE:
  - done = 1, busy = 0, cnt_en = 0, cnt_clr = 0. q holds at term_r.
  - Always go to IDLE next cycle. start is ignored during DONE.
- Latency (start accepted at edge k):
  - CLEAR is in cycle k+1; RUN begins in cycle k+2 with q = 0.
  - The first hit occurs in cycle k+2+T, where T = term_r.
  - A one-shot run gives done in cycle k+3+T.
  - A periodic run gives wrap every T+1 cycles.
- term = 0: hit in the first RUN cycle. Periodic mode then gives wrap every cycle.
- start while busy is ignored. term, mode and repeat_cnt changes after acceptance have no effect until the next accepted start.
- stop in IDLE or DONE has no effect.

Test Plan:
- Reset, then rst = 0 with no start -> all outputs 0, state IDLE for 10 cycles; q frozen (cnt_en = 0).
- One-shot, term = 5, start pulsed at edge k -> cnt_clr in cycle k+1; q = 0..5 over cycles k+2..k+7; wrap and cnt_en = 0 at k+7; done at k+8; busy = 0 at k+8; pass_cnt = 1.
- Periodic, term = 3, repeat_cnt = 3 -> wrap at cycles k+5, k+9, k+13; pass_cnt = 1, 2, 3; done at k+14; exactly 3 wrap pulses.
- Periodic, term = 15, repeat_cnt = 0 -> wrap every 16 cycles for 300 cycles; no done; pass_cnt wraps 15 -> 0. Then stop -> IDLE next cycle, cnt_en = 0, no done.
- Abort and priority: stop asserted in the hit cycle (term = 2) -> no done, no wrap, back to IDLE. Start+stop together in IDLE -> stays IDLE. Start during RUN -> ignored, latched term unchanged.
- rst pulsed in RUN with q = 2 -> next cycle all outputs 0 and pass_cnt = 0. A following start with term = 0 in one-shot mode -> done 3 cycles after the accepting edge.
